// File: rtl/wash_sequencer.sv
// Washing-machine phase sequencer: steps the phase timer through fill, heat,
// wash, rinse and spin, and drives registered actuator and status outputs.
module wash_sequencer #(
  parameter int unsigned RINSE_COUNT   = 2,
  parameter logic [7:0]  PHASE_TIMEOUT = 8'd200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       door_closed,
  input  logic       pause,
  input  logic       cancel,
  input  logic       cold_wash,
  input  logic       sig_Full,
  input  logic       sig_Temperature,
  input  logic       sig_Completed,
  output logic [2:0] state,
  output logic       water_valve,
  output logic       heater_on,
  output logic       motor_on,
  output logic       drain_valve,
  output logic       door_lock,
  output logic       done,
  output logic       fault
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_HEAT   = 3'd3;
  localparam logic [2:0] S_WASH   = 3'd4;
  localparam logic [2:0] S_RINSE  = 3'd5;
  localparam logic [2:0] S_SPIN   = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [3:0] RINSE_LIM = 4'(RINSE_COUNT);

  logic [2:0] phase_q, phase_d;
  logic [2:0] next_q, next_d;
  logic [2:0] rinse_q, rinse_d;
  logic [7:0] tmo_q, tmo_d;
  logic       cold_q, cold_d;
  logic       first_q, first_d;
  logic       paused_q, paused_d;
  logic       fault_q, fault_d;

  logic [2:0] state_q, state_d;
  logic       water_q, water_d;
  logic       heater_q, heater_d;
  logic       motor_q, motor_d;
  logic       drain_q, drain_d;
  logic       lock_q, lock_d;
  logic       done_q, done_d;

  logic       active_ph;
  logic       timed_ph;
  logic       hold_req;
  logic       cancel_ok;
  logic       tmo_hit;
  logic       flag_sel;
  logic       flag_hit;
  logic [3:0] rinse_inc;
  logic [8:0] tmo_inc;

  // Classify the current phase and qualify the events that may act on it.
  always_comb begin
    active_ph = (phase_q != S_IDLE) && (phase_q != S_DONE);
    timed_ph  = active_ph && (phase_q != S_SETTLE);
    hold_req  = pause || !door_closed;
    cancel_ok = cancel && (phase_q != S_IDLE) && (phase_q != S_SPIN);
    tmo_inc   = {1'b0, tmo_q} + 9'd1;
    tmo_hit   = timed_ph && !paused_q && (tmo_inc >= {1'b0, PHASE_TIMEOUT});
    rinse_inc = {1'b0, rinse_q} + 4'd1;
    case (phase_q)
      S_FILL:                  flag_sel = sig_Full;
      S_HEAT:                  flag_sel = sig_Temperature;
      S_WASH, S_RINSE, S_SPIN: flag_sel = sig_Completed;
      default:                 flag_sel = 1'b0;
    endcase
    // first_q masks flags left over from the phase just exited
    flag_hit = flag_sel && !first_q;
  end

  // Phase sequencing in priority order: cancel, timeout, pause, resume, normal flow.
  always_comb begin
    phase_d  = phase_q;
    next_d   = next_q;
    rinse_d  = rinse_q;
    tmo_d    = tmo_q;
    cold_d   = cold_q;
    first_d  = first_q;
    paused_d = paused_q;
    fault_d  = fault_q;
    if (cancel_ok) begin
      phase_d  = S_SETTLE;
      next_d   = S_SPIN;
      paused_d = 1'b0;
      tmo_d    = 8'd0;
      first_d  = 1'b1;
    end else if (tmo_hit) begin
      phase_d  = S_IDLE;
      paused_d = 1'b0;
      tmo_d    = 8'd0;
      first_d  = 1'b0;
      fault_d  = 1'b1;
    end else if (active_ph && hold_req) begin
      paused_d = 1'b1;
    end else if (paused_q) begin
      // resume restarts the frozen phase from its beginning
      paused_d = 1'b0;
      tmo_d    = 8'd0;
      first_d  = 1'b1;
    end else begin
      case (phase_q)
        S_IDLE: begin
          if (start && door_closed) begin
            phase_d = S_SETTLE;
            next_d  = S_FILL;
            cold_d  = cold_wash;
            rinse_d = 3'd0;
            tmo_d   = 8'd0;
            first_d = 1'b1;
            fault_d = 1'b0;
          end else begin
            phase_d = S_IDLE;
          end
        end
        S_SETTLE: begin
          phase_d = next_q;
          tmo_d   = 8'd0;
          first_d = 1'b1;
        end
        S_FILL, S_HEAT, S_WASH, S_RINSE, S_SPIN: begin
          tmo_d   = tmo_q + 8'd1;
          first_d = 1'b0;
          if (flag_hit) begin
            tmo_d   = 8'd0;
            first_d = 1'b1;
            case (phase_q)
              S_FILL: begin
                phase_d = S_SETTLE;
                next_d  = cold_q ? S_WASH : S_HEAT;
              end
              S_HEAT: begin
                phase_d = S_SETTLE;
                next_d  = S_WASH;
              end
              S_WASH: begin
                phase_d = S_SETTLE;
                next_d  = S_RINSE;
              end
              S_RINSE: begin
                phase_d = S_SETTLE;
                rinse_d = rinse_inc[2:0];
                next_d  = (rinse_inc < RINSE_LIM) ? S_RINSE : S_SPIN;
              end
              S_SPIN:  phase_d = S_DONE;
              default: phase_d = S_IDLE;
            endcase
          end else begin
            phase_d = phase_q;
          end
        end
        S_DONE: begin
          if (!door_closed) begin
            phase_d = S_IDLE;
          end else begin
            phase_d = S_DONE;
          end
        end
        default: phase_d = S_IDLE;
      endcase
    end
  end

  // Decode the upcoming phase into the values the output registers will hold.
  always_comb begin
    state_d  = paused_d ? S_SETTLE : phase_d;
    water_d  = 1'b0;
    heater_d = 1'b0;
    motor_d  = 1'b0;
    drain_d  = 1'b0;
    lock_d   = (phase_d != S_IDLE) && (phase_d != S_DONE);
    done_d   = (phase_d == S_DONE);
    if (!paused_d) begin
      case (phase_d)
        S_FILL:           water_d  = 1'b1;
        S_HEAT:           heater_d = 1'b1;
        S_WASH, S_RINSE:  motor_d  = 1'b1;
        S_SPIN: begin
          motor_d = 1'b1;
          drain_d = 1'b1;
        end
        default: water_d = 1'b0;
      endcase
    end else begin
      water_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q  <= S_IDLE;
      next_q   <= S_IDLE;
      rinse_q  <= 3'd0;
      tmo_q    <= 8'd0;
      cold_q   <= 1'b0;
      first_q  <= 1'b0;
      paused_q <= 1'b0;
      fault_q  <= 1'b0;
      state_q  <= S_IDLE;
      water_q  <= 1'b0;
      heater_q <= 1'b0;
      motor_q  <= 1'b0;
      drain_q  <= 1'b0;
      lock_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      next_q   <= next_d;
      rinse_q  <= rinse_d;
      tmo_q    <= tmo_d;
      cold_q   <= cold_d;
      first_q  <= first_d;
      paused_q <= paused_d;
      fault_q  <= fault_d;
      state_q  <= state_d;
      water_q  <= water_d;
      heater_q <= heater_d;
      motor_q  <= motor_d;
      drain_q  <= drain_d;
      lock_q   <= lock_d;
      done_q   <= done_d;
    end
  end

  assign state       = state_q;
  assign water_valve = water_q;
  assign heater_on   = heater_q;
  assign motor_on    = motor_q;
  assign drain_valve = drain_q;
  assign door_lock   = lock_q;
  assign done        = done_q;
  assign fault       = fault_q;

endmodule

// File: doc/wash_sequencer.md
Name: wash_sequencer

Overview:
- Top-level washing-machine controller. Sequences the phase timer through fill, heat, wash, rinse and spin, and drives the actuator enables.
- Consumes the timer's sig_Full, sig_Temperature and sig_Completed flags, and drives the 3-bit state code that the timer decodes.
- Sits between the user panel inputs (start, door, pause, cancel, cold-wash select) and the timer/actuator layer.

Parameters:
- RINSE_COUNT, 2, number of rinse passes (1..7).
- PHASE_TIMEOUT, 8'd200, maximum clocks spent in any timed phase before a fault is declared (1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; begins a cycle from IDLE.
- door_closed  in  1  1 = door shut.
- pause  in  1  level; suspends the current phase.
- cancel  in  1  level; aborts the cycle.
- cold_wash  in  1  sampled at start; 1 = skip HEAT_WATER.
- sig_Full  in  1  timer: fill target reached.
- sig_Temperature  in  1  timer: heat target reached.
- sig_Completed  in  1  timer: wash/rinse/spin duration reached.
- state  out  3  phase code to timer.
- water_valve  out  1  inlet valve enable.
- heater_on  out  1  heater enable.
- motor_on  out  1  drum motor enable.
- drain_valve  out  1  drain pump enable.
- door_lock  out  1  door latch.
- done  out  1  cycle finished.
- fault  out  1  phase timeout occurred (sticky).

Behaviour:
- State codes: IDLE=0, SETTLE=1, FILL_WATER=2, HEAT_WATER=3, WASH=4, RINSE=5, SPIN=6, DONE=7.
- The state output equals the internal phase, except it shows SETTLE (1) while paused.
- Reset: internal phase IDLE, all outputs 0, rinse counter 0, timeout counter 0, cold flag 0.
- All outputs are registered. Transitions take effect one clock after the qualifying input is sampled.
- IDLE -> SETTLE when start=1 and door_closed=1. On that edge, cold_wash is latched, rinse counter and fault are cleared, and the next-phase register is set to FILL_WATER.
- SETTLE: lasts exactly 1 cycle, then enters the next-phase register. It exists so the timer sees a non-phase code and clears its counters between phases.
- Phase sequence:
  - FILL_WATER --sig_Full--> SETTLE, next = HEAT_WATER, or WASH if the cold flag is set.
  - HEAT_WATER --sig_Temperature--> SETTLE, next = WASH.
  - WASH --sig_Completed--> SETTLE, next = RINSE.
  - RINSE --sig_Completed--> rinse counter +1. If the new count < RINSE_COUNT: SETTLE, next = RINSE. Otherwise: SETTLE, next = SPIN.
  - SPIN --sig_Completed--> DONE.
- Completion flags are ignored during the first cycle of each phase entry, to mask flags still set from the previous phase.
- DONE: done=1, door_lock=0, all actuators off. DONE -> IDLE when door_closed=0. start is ignored while in DONE.
- Actuators:
  - FILL: water_valve=1.
  - HEAT: heater_on=1.
  - WASH and RINSE: motor_on=1.
  - SPIN: motor_on=1 and drain_valve=1.
  - door_lock=1 in every state from SETTLE through SPIN.
- Pause: in any phase 1..6, pause=1 or door_closed=0 freezes the internal phase and forces all actuators to 0.
  - state shows 1 and door_lock stays 1.
  - The timeout counter holds.
  - On resume, the frozen phase is re-entered from its start: the timeout counter is cleared and the first-cycle flag mask applies again.
- Timeout: the counter increments each unpaused cycle in phases 2..6 and clears on every phase entry. When it reaches PHASE_TIMEOUT: fault=1, go to IDLE, actuators off, door_lock=0. fault stays at 1 until the next accepted start or reset.
- Cancel: in any non-IDLE state, cancel=1 -> SETTLE, next = SPIN, drains and spins the load. A cancel already in SPIN is ignored. Cancel takes priority over pause and over completion flags.
- Simultaneous events: priority is reset > cancel > timeout > pause > completion flag.
- Reset mid-cycle returns to IDLE immediately, with all outputs 0.

Test Plan:
- Full hot cycle, RINSE_COUNT=2, each flag pulsed after 3 cycles in its phase -> state goes 2,1,3,1,4,1,5,1,5,1,6,7. done=1 in 7. door_lock=1 throughout 1..6.
- cold_wash=1 at start -> HEAT_WATER (3) never appears. FILL goes to SETTLE then WASH (4). heater_on is never 1.
- Pause asserted for 5 cycles in WASH -> state=1, motor_on=0, door_lock=1. On release, state=4 and the timeout counter restarts at 0.
- sig_Full held at 0 with PHASE_TIMEOUT=10 -> fault=1 and state=0 exactly 10 cycles after entering FILL. The next start clears fault.
- cancel pulsed in RINSE -> SETTLE, then SPIN with drain_valve=1, then DONE. Opening the door in DONE returns to IDLE.
- reset asserted in HEAT_WATER -> next cycle state=0 and all outputs 0. start with door_closed=0 is ignored.
